// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch-prediction path: the address width, the
// record carried by each pipeline slot and the misprediction cause codes.
// The BTB and the branch resolver both import this package so that they
// agree on field layout.
// ---------------------------------------------------------------------------
package bp_pkg;

   localparam int XLEN = 32;

   // One in-flight instruction together with the prediction made for it
   // at fetch time.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic            pred_taken;
      logic [XLEN-1:0] pred_target;
   } bp_slot_t;

   // Why the EXE stage is redirecting fetch.
   //   DIR_NT : predicted not-taken, resolved taken
   //   DIR_T  : predicted taken, resolved not-taken
   //   TARGET : predicted and resolved taken, but to a different address
   //   NONBR  : a non-branch that the BTB claimed was taken
   typedef enum logic [2:0] {
      NONE,
      DIR_NT,
      DIR_T,
      TARGET,
      NONBR
   } bp_cause_e;

endpackage

// File: rtl/bp_sat_counter.sv
// ---------------------------------------------------------------------------
// bp_sat_counter
// Saturating up-counter used for performance statistics. Once it has reached
// all-ones it stays there, so a long run never shows a misleading small value.
//
// Ports:
//   clk    in  1  core clock
//   rst    in  1  asynchronous, active-low reset (clears the count)
//   inc    in  1  increment on this edge
//   count  out W  current count
// ---------------------------------------------------------------------------
module bp_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on request, but hold once the all-ones ceiling is reached.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
// Carries each fetched instruction's BTB prediction through ID into EXE,
// compares it with the resolved outcome there, drives the BTB update port
// and redirects fetch on a misprediction. Two saturating counters record
// resolved branches and mispredict redirects.
//
// Ports:
//   clk              in   1      core clock
//   rst              in   1      asynchronous, active-low reset
//   valid_if         in   1      IF holds a real instruction
//   pc_if            in   XLEN   PC of the IF instruction
//   predict_jump_if  in   1      BTB prediction for pc_if
//   jump_addr_if     in   XLEN   BTB predicted target for pc_if
//   stall            in   1      hold ID, insert a bubble into EXE
//   flush_ext        in   1      kill EXE, ID and IF contents
//   is_branch_exe    in   1      EXE instruction is a branch/jal/jalr
//   taken_exe        in   1      resolved direction
//   target_exe       in   XLEN   resolved taken target
//   upd_valid        out  1      BTB update strobe
//   upd_pc           out  XLEN   BTB update PC
//   upd_taken        out  1      BTB update direction
//   upd_target       out  XLEN   BTB update target
//   redirect         out  1      misprediction, fetch from redirect_pc
//   redirect_pc      out  XLEN   corrected fetch address
//   branch_cnt       out  CNT_W  resolved branches (saturating)
//   mispredict_cnt   out  CNT_W  mispredict redirects (saturating)
// ---------------------------------------------------------------------------
module branch_resolver #(
   parameter int XLEN  = bp_pkg::XLEN,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_if,
   input  logic [XLEN-1:0]  pc_if,
   input  logic             predict_jump_if,
   input  logic [XLEN-1:0]  jump_addr_if,
   input  logic             stall,
   input  logic             flush_ext,
   input  logic             is_branch_exe,
   input  logic             taken_exe,
   input  logic [XLEN-1:0]  target_exe,
   output logic             upd_valid,
   output logic [XLEN-1:0]  upd_pc,
   output logic             upd_taken,
   output logic [XLEN-1:0]  upd_target,
   output logic             redirect,
   output logic [XLEN-1:0]  redirect_pc,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);

   import bp_pkg::*;

   bp_slot_t  id_slot;
   bp_slot_t  exe_slot;
   bp_cause_e cause;
   logic      act;

   // Slot pipeline. A redirect or external flush empties both slots, since
   // everything younger than the EXE instruction is on the wrong path. A
   // stall keeps ID for another cycle and sends a bubble into EXE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_slot  <= '0;
         exe_slot <= '0;
      end else if (redirect || flush_ext) begin
         id_slot  <= '0;
         exe_slot <= '0;
      end else if (stall) begin
         exe_slot <= '0;
      end else begin
         exe_slot <= id_slot;
         id_slot  <= '{valid:       valid_if,
                       pc:          pc_if,
                       pred_taken:  predict_jump_if,
                       pred_target: jump_addr_if};
      end
   end

   // Classify the EXE instruction. A flush arriving in the same cycle means
   // this instruction is already dead, so it must neither train the BTB nor
   // redirect. A non-branch predicted taken points at a stale or aliased BTB
   // entry; fetch must resume sequentially.
   always_comb begin
      act   = exe_slot.valid & ~flush_ext;
      cause = NONE;
      if (act) begin
         if (is_branch_exe) begin
            if (!exe_slot.pred_taken && taken_exe) begin
               cause = DIR_NT;
            end else if (exe_slot.pred_taken && !taken_exe) begin
               cause = DIR_T;
            end else if (exe_slot.pred_taken && taken_exe &&
                         (exe_slot.pred_target != target_exe)) begin
               cause = TARGET;
            end
         end else if (exe_slot.pred_taken) begin
            cause = NONBR;
         end
      end
   end

   // BTB update and redirect outputs. Everything is forced to zero when not
   // active so the BTB and PC mux never see stale addresses.
   always_comb begin
      upd_valid   = act & is_branch_exe;
      upd_pc      = '0;
      upd_taken   = 1'b0;
      upd_target  = '0;
      redirect    = (cause != NONE);
      redirect_pc = '0;
      if (upd_valid) begin
         upd_pc     = exe_slot.pc;
         upd_taken  = taken_exe;
         upd_target = target_exe;
      end
      case (cause)
         DIR_NT, TARGET: redirect_pc = target_exe;
         DIR_T, NONBR:   redirect_pc = exe_slot.pc + XLEN'(4);
         default:        redirect_pc = '0;
      endcase
   end

   bp_sat_counter #(.W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (upd_valid),
      .count (branch_cnt)
   );

   bp_sat_counter #(.W(CNT_W)) u_mispredict_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (redirect),
      .count (mispredict_cnt)
   );

endmodule
